// File: rtl/wb_stage3_if.sv
// wb_stage3_if
//   Bundles the signals between the pipeline and the writeback stage.
//   It carries the pipeline controls, the stage-2 instruction fields, the
//   data-memory read word, and the register-file write / forwarding outputs.
//   The clock and reset are not part of this bundle.
//   Modports:
//     slave  : the writeback stage (consumes the stage-2 fields, drives rd/wb_data/we)
//     master : the surrounding pipeline (drives the stage-2 fields, consumes the write port)
interface wb_stage3_if;
   logic        stall;
   logic        kill;
   logic        s2_valid;
   logic [4:0]  s2_rd;
   logic        s2_we;
   logic [1:0]  s2_wb_sel;
   logic [2:0]  s2_funct3;
   logic [31:0] s2_alu_result;
   logic [31:0] s2_pc_plus4;
   logic [31:0] dmem_rdata;
   logic [4:0]  rd;
   logic [31:0] wb_data;
   logic        we;
   logic        fwd_valid;

   modport slave (
      input  stall, kill, s2_valid, s2_rd, s2_we, s2_wb_sel, s2_funct3,
             s2_alu_result, s2_pc_plus4, dmem_rdata,
      output rd, wb_data, we, fwd_valid
   );

   modport master (
      output stall, kill, s2_valid, s2_rd, s2_we, s2_wb_sel, s2_funct3,
             s2_alu_result, s2_pc_plus4, dmem_rdata,
      input  rd, wb_data, we, fwd_valid
   );
endinterface

// File: rtl/wb_stage3.sv
// wb_stage3
//   Stage-3 (writeback) of the 3-stage RISC-V pipeline.
//   - Registers the stage-2 instruction.
//   - Selects the writeback value: the ALU result, the aligned and extended
//     load data, or PC+4.
//   - Drives the register-file write port.
//   - Exports the same port as the stage-1 forwarding source.
//   Ports:
//     clk     : clock; all state updates on the rising edge
//     reset   : synchronous active-high reset
//     bus     : wb_stage3_if.slave
//               inputs : stall, kill, s2_* instruction fields, dmem_rdata
//               outputs: rd, wb_data, we, fwd_valid
//     instret : 64-bit retired-instruction count; present only when
//               WB_STAGE3_INSTRET_EN is defined
//   Optional feature macro: WB_STAGE3_INSTRET_EN
module wb_stage3 #(
   parameter int         XLEN       = 32,
   parameter logic [1:0] WB_SEL_ALU = 2'd0,
   parameter logic [1:0] WB_SEL_MEM = 2'd1,
   parameter logic [1:0] WB_SEL_PC4 = 2'd2
) (
   input  logic            clk,
   input  logic            reset,
   wb_stage3_if.slave      bus
`ifdef WB_STAGE3_INSTRET_EN
   ,
   output logic [63:0]     instret
`endif
);

   logic            valid_q;
   logic [4:0]      rd_q;
   logic            we_q;
   logic [1:0]      wb_sel_q;
   logic [2:0]      funct3_q;
   logic [XLEN-1:0] alu_q;
   logic [XLEN-1:0] pc4_q;

   logic [1:0]      off;
   logic [7:0]      byte_sel;
   logic [15:0]     half_sel;
   logic [XLEN-1:0] load_data;
   logic [XLEN-1:0] sel_data;

   // Priority: reset > stall > kill > load.
   // A kill only clears valid_q. The other fields still load, but they are
   // don't-care because valid_q gates every output.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q  <= 1'b0;
         rd_q     <= '0;
         we_q     <= 1'b0;
         wb_sel_q <= '0;
         funct3_q <= '0;
         alu_q    <= '0;
         pc4_q    <= '0;
      end else if (!bus.stall) begin
         valid_q  <= bus.s2_valid & ~bus.kill;
         rd_q     <= bus.s2_rd;
         we_q     <= bus.s2_we;
         wb_sel_q <= bus.s2_wb_sel;
         funct3_q <= bus.s2_funct3;
         alu_q    <= bus.s2_alu_result;
         pc4_q    <= bus.s2_pc_plus4;
      end
   end

   // Load alignment. The byte offset comes from the low bits of the address,
   // which is the registered ALU result. Halfword accesses ignore off[0].
   always_comb begin
      off = alu_q[1:0];
      byte_sel = 8'h00;
      case (off)
         2'd0: byte_sel = bus.dmem_rdata[7:0];
         2'd1: byte_sel = bus.dmem_rdata[15:8];
         2'd2: byte_sel = bus.dmem_rdata[23:16];
         2'd3: byte_sel = bus.dmem_rdata[31:24];
         default: byte_sel = 8'h00;
      endcase
      half_sel = off[1] ? bus.dmem_rdata[31:16] : bus.dmem_rdata[15:0];
      load_data = bus.dmem_rdata;
      case (funct3_q)
         3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
         3'b100:  load_data = {24'h0, byte_sel};
         3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
         3'b101:  load_data = {16'h0, half_sel};
         default: load_data = bus.dmem_rdata;
      endcase
   end

   always_comb begin
      sel_data = '0;
      case (wb_sel_q)
         WB_SEL_ALU: sel_data = alu_q;
         WB_SEL_MEM: sel_data = load_data;
         WB_SEL_PC4: sel_data = pc4_q;
         default:    sel_data = '0;
      endcase
   end

   // During a stall the instruction stays in place with we low. It therefore
   // writes exactly once, on the first cycle where stall is low.
   // rd_q == 0 suppresses the write, which protects x0.
   assign bus.we        = valid_q & we_q & (rd_q != 5'd0) & ~bus.stall;
   assign bus.fwd_valid = bus.we;
   assign bus.rd        = rd_q;
   assign bus.wb_data   = valid_q ? sel_data : '0;

`ifdef WB_STAGE3_INSTRET_EN
   // Every instruction that leaves the stage is counted, including those
   // that do not write a register.
   always_ff @(posedge clk) begin
      if (reset)
         instret <= 64'd0;
      else if (valid_q && !bus.stall)
         instret <= instret + 64'd1;
   end
`endif

endmodule

// File: tb/tb_wb_stage3.sv
module tb_wb_stage3;
   logic clk = 1'b0;
   logic reset;
   int   n_vec = 0;
   int   n_err = 0;
   int   n_wr7 = 0;

   wb_stage3_if bus();
`ifdef WB_STAGE3_INSTRET_EN
   logic [63:0] instret;
`endif

   wb_stage3 dut (
      .clk     (clk),
      .reset   (reset),
      .bus     (bus)
`ifdef WB_STAGE3_INSTRET_EN
      ,
      .instret (instret)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic v, input logic [4:0] r, input logic w, input logic [1:0] sel,
                        input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] pc4);
      bus.s2_valid      = v;
      bus.s2_rd         = r;
      bus.s2_we         = w;
      bus.s2_wb_sel     = sel;
      bus.s2_funct3     = f3;
      bus.s2_alu_result = alu;
      bus.s2_pc_plus4   = pc4;
   endtask

   task automatic idle();
      issue(1'b0, 5'd0, 1'b0, 2'd0, 3'd0, 32'h0, 32'h0);
   endtask

   initial begin
      reset = 1'b1;
      bus.stall = 1'b0;
      bus.kill = 1'b0;
      bus.dmem_rdata = 32'h8077F0A5;
      idle();
      tick();
      tick();
      chk("rst_we", {63'h0, bus.we}, 64'd0);
      chk("rst_rd", {59'h0, bus.rd}, 64'd0);
      chk("rst_data", {32'h0, bus.wb_data}, 64'd0);
      chk("rst_fwd", {63'h0, bus.fwd_valid}, 64'd0);
`ifdef WB_STAGE3_INSTRET_EN
      chk("rst_instret", instret, 64'd0);
`endif
      reset = 1'b0;

      // ALU writeback
      issue(1'b1, 5'd5, 1'b1, 2'd0, 3'd2, 32'hDEADBEEF, 32'h0);
      tick();
      chk("alu_we", {63'h0, bus.we}, 64'd1);
      chk("alu_fwd", {63'h0, bus.fwd_valid}, 64'd1);
      chk("alu_rd", {59'h0, bus.rd}, 64'd5);
      chk("alu_data", {32'h0, bus.wb_data}, 64'hDEADBEEF);
      idle();
      tick();
      chk("alu_next_we", {63'h0, bus.we}, 64'd0);
      chk("alu_next_data", {32'h0, bus.wb_data}, 64'd0);

      // Load formats on dmem_rdata = 8077F0A5
      issue(1'b1, 5'd3, 1'b1, 2'd1, 3'b000, 32'h00000100, 32'h0);
      tick();
      chk("lb_off0", {32'h0, bus.wb_data}, 64'hFFFFFFA5);
      issue(1'b1, 5'd3, 1'b1, 2'd1, 3'b100, 32'h00000101, 32'h0);
      tick();
      chk("lbu_off1", {32'h0, bus.wb_data}, 64'h000000F0);
      issue(1'b1, 5'd3, 1'b1, 2'd1, 3'b001, 32'h00000102, 32'h0);
      tick();
      chk("lh_off2", {32'h0, bus.wb_data}, 64'hFFFF8077);
      issue(1'b1, 5'd3, 1'b1, 2'd1, 3'b101, 32'h00000103, 32'h0);
      tick();
      chk("lhu_off3", {32'h0, bus.wb_data}, 64'h00008077);
      issue(1'b1, 5'd3, 1'b1, 2'd1, 3'b010, 32'h00000101, 32'h0);
      tick();
      chk("lw_off1", {32'h0, bus.wb_data}, 64'h8077F0A5);
      issue(1'b1, 5'd3, 1'b1, 2'd1, 3'b000, 32'h00000103, 32'h0);
      tick();
      chk("lb_off3", {32'h0, bus.wb_data}, 64'hFFFFFF80);
      issue(1'b1, 5'd3, 1'b1, 2'd1, 3'b011, 32'h00000102, 32'h0);
      tick();
      chk("ld_other_code", {32'h0, bus.wb_data}, 64'h8077F0A5);
      issue(1'b1, 5'd3, 1'b1, 2'd3, 3'b000, 32'h12345678, 32'h9);
      tick();
      chk("sel3_data", {32'h0, bus.wb_data}, 64'd0);

      // x0 and PC+4
      issue(1'b1, 5'd0, 1'b1, 2'd2, 3'd0, 32'h55, 32'h00001004);
      tick();
      chk("x0_we", {63'h0, bus.we}, 64'd0);
      chk("pc4_data_x0", {32'h0, bus.wb_data}, 64'h00001004);
      issue(1'b1, 5'd1, 1'b1, 2'd2, 3'd0, 32'h55, 32'h00001004);
      tick();
      chk("pc4_we_x1", {63'h0, bus.we}, 64'd1);
      chk("pc4_data_x1", {32'h0, bus.wb_data}, 64'h00001004);

      // Stall holds rd=7 for 3 cycles, then exactly one write
      issue(1'b1, 5'd7, 1'b1, 2'd0, 3'd0, 32'd5, 32'h0);
      tick();
      bus.stall = 1'b1;
      issue(1'b1, 5'd9, 1'b1, 2'd0, 3'd0, 32'd99, 32'h0);
      #1;
      for (int i = 0; i < 3; i++) begin
         chk("stall_we", {63'h0, bus.we}, 64'd0);
         chk("stall_rd", {59'h0, bus.rd}, 64'd7);
         if (bus.we && bus.rd == 5'd7) n_wr7++;
         if (i < 2) tick();
      end
      bus.stall = 1'b0;
      #1;
      chk("unstall_we", {63'h0, bus.we}, 64'd1);
      chk("unstall_data", {32'h0, bus.wb_data}, 64'd5);
      if (bus.we && bus.rd == 5'd7) n_wr7++;
      idle();
      tick();
      if (bus.we && bus.rd == 5'd7) n_wr7++;
      chk("stall_one_write", 64'(n_wr7), 64'd1);

      // Kill
      bus.kill = 1'b1;
      issue(1'b1, 5'd4, 1'b1, 2'd0, 3'd0, 32'h1234, 32'h0);
      tick();
      bus.kill = 1'b0;
      chk("kill_we", {63'h0, bus.we}, 64'd0);
      chk("kill_data", {32'h0, bus.wb_data}, 64'd0);

      // Stall with kill: stall wins and the held instruction is unaffected
      issue(1'b1, 5'd6, 1'b1, 2'd0, 3'd0, 32'd66, 32'h0);
      tick();
      bus.stall = 1'b1;
      bus.kill = 1'b1;
      idle();
      tick();
      chk("stallkill_rd", {59'h0, bus.rd}, 64'd6);
      chk("stallkill_we", {63'h0, bus.we}, 64'd0);
      bus.stall = 1'b0;
      bus.kill = 1'b0;
      #1;
      chk("stallkill_after_we", {63'h0, bus.we}, 64'd1);
      chk("stallkill_after_data", {32'h0, bus.wb_data}, 64'd66);

      // Reset during a stalled valid instruction
      issue(1'b1, 5'd8, 1'b1, 2'd0, 3'd0, 32'd88, 32'h0);
      tick();
      idle();
      bus.stall = 1'b1;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      bus.stall = 1'b0;
      #1;
      chk("rststall_we", {63'h0, bus.we}, 64'd0);
      chk("rststall_data", {32'h0, bus.wb_data}, 64'd0);
      chk("rststall_rd", {59'h0, bus.rd}, 64'd0);
`ifdef WB_STAGE3_INSTRET_EN
      chk("rststall_instret", instret, 64'd0);

      // Counter: 4 valid (one with we=0), 1 killed, 2 stall cycles
      issue(1'b1, 5'd1, 1'b1, 2'd0, 3'd0, 32'd1, 32'h0);
      tick();
      issue(1'b1, 5'd2, 1'b0, 2'd0, 3'd0, 32'd2, 32'h0);
      tick();
      bus.stall = 1'b1;
      tick();
      tick();
      bus.stall = 1'b0;
      issue(1'b1, 5'd3, 1'b1, 2'd0, 3'd0, 32'd3, 32'h0);
      tick();
      bus.kill = 1'b1;
      issue(1'b1, 5'd4, 1'b1, 2'd0, 3'd0, 32'd4, 32'h0);
      tick();
      bus.kill = 1'b0;
      issue(1'b1, 5'd5, 1'b1, 2'd0, 3'd0, 32'd5, 32'h0);
      tick();
      idle();
      tick();
      tick();
      chk("instret_count", instret, 64'd4);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
